// File: rtl/poly_note_pkg.sv
// Shared types and lookup functions for the polyphonic note allocator.
// Keycode map, octave base table and allocator FSM states.
package poly_note_pkg;

    typedef enum logic [1:0] {IDLE, REL, PRESS, DONE} state_t;

    localparam logic [7:0] ROLLOVER = 8'h01;
    localparam logic [7:0] NONE     = 8'h00;

    typedef struct packed {
        logic       hit;
        logic [4:0] offset;
    } keymap_t;

    function automatic keymap_t key_map(input logic [7:0] kc);
        keymap_t r;
        r = '0;
        case (kc)
            8'h1D: r = '{1'b1, 5'd0};
            8'h1B: r = '{1'b1, 5'd2};
            8'h06: r = '{1'b1, 5'd4};
            8'h19: r = '{1'b1, 5'd6};
            8'h05: r = '{1'b1, 5'd8};
            8'h11: r = '{1'b1, 5'd10};
            8'h10: r = '{1'b1, 5'd12};
            8'h36: r = '{1'b1, 5'd14};
            8'h37: r = '{1'b1, 5'd16};
            8'h38: r = '{1'b1, 5'd18};
            8'h04: r = '{1'b1, 5'd5};
            8'h16: r = '{1'b1, 5'd7};
            8'h07: r = '{1'b1, 5'd9};
            8'h09: r = '{1'b1, 5'd11};
            8'h0A: r = '{1'b1, 5'd13};
            8'h0B: r = '{1'b1, 5'd15};
            8'h0D: r = '{1'b1, 5'd17};
            8'h0E: r = '{1'b1, 5'd19};
            8'h0F: r = '{1'b1, 5'd21};
            8'h33: r = '{1'b1, 5'd23};
            8'h34: r = '{1'b1, 5'd25};
            8'h14: r = '{1'b1, 5'd10};
            8'h1A: r = '{1'b1, 5'd12};
            8'h08: r = '{1'b1, 5'd14};
            8'h15: r = '{1'b1, 5'd16};
            8'h17: r = '{1'b1, 5'd18};
            8'h1C: r = '{1'b1, 5'd20};
            8'h18: r = '{1'b1, 5'd22};
            8'h0C: r = '{1'b1, 5'd24};
            8'h12: r = '{1'b1, 5'd26};
            8'h13: r = '{1'b1, 5'd28};
            8'h2F: r = '{1'b1, 5'd30};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] octave_base(input logic [7:0] ob);
        logic [6:0] b;
        case (ob)
            8'h80: b = 7'd6;
            8'h40: b = 7'd18;
            8'h20: b = 7'd30;
            8'h10: b = 7'd42;
            8'h08: b = 7'd54;
            8'h04: b = 7'd66;
            8'h02: b = 7'd78;
            default: b = 7'd90;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/voice_picker.sv
// Chooses the voice to receive a new note: lowest free voice,
// otherwise the oldest active voice (lowest index on equal age).
module voice_picker #(
    parameter int NUM_VOICES = 4,
    parameter int IDX_W      = 2,
    parameter int AGE_W      = 2
) (
    input  logic [NUM_VOICES-1:0]            active,
    input  logic [NUM_VOICES-1:0][AGE_W-1:0] ages,
    output logic [IDX_W-1:0]                 free_idx,
    output logic                             free_hit,
    output logic [IDX_W-1:0]                 steal_idx
);

    logic [AGE_W-1:0] best_age;

    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!active[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        steal_idx = '0;
        best_age  = ages[0];
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (ages[i] > best_age) begin
                best_age  = ages[i];
                steal_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/poly_note_alloc.sv
// Keyboard-report to synth-voice allocator: releases voices whose keys
// vanished, then allocates newly pressed keys one slot per cycle.
module poly_note_alloc
    import poly_note_pkg::*;
#(
    parameter int NUM_KEYS   = 6,
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W     = 7
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         report_valid,
    output logic                         report_ready,
    input  logic [8*NUM_KEYS-1:0]        keycodes,
    input  logic [7:0]                   octaveBase,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_trig,
    output logic [NUM_VOICES-1:0]        voice_off
);

    localparam int IDX_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int AGE_W    = IDX_W;
    localparam int SCAN_MAX = (NUM_VOICES > NUM_KEYS) ? NUM_VOICES : NUM_KEYS;
    localparam int CNT_W    = $clog2(SCAN_MAX) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    state_t                              state;
    logic [CNT_W-1:0]                    idx;
    logic [NUM_KEYS-1:0][7:0]            rep;
    logic [NUM_KEYS-1:0]                 held_start;
    logic [NUM_VOICES-1:0][7:0]          vkey;
    logic [NUM_VOICES-1:0][AGE_W-1:0]    age;
    logic [NUM_VOICES-1:0][NOTE_W-1:0]   vnote;

    logic [IDX_W-1:0]                    free_idx;
    logic                                free_hit;
    logic [IDX_W-1:0]                    steal_idx;
    logic [IDX_W-1:0]                    target;

    logic                                rollover;
    logic [7:0]                          cur_key;
    logic                                cur_held_start;
    logic                                held_now;
    keymap_t                             km;
    logic                                alloc;
    logic [NOTE_W-1:0]                   new_note;
    logic [NUM_VOICES-1:0]               rel_drop;
    logic [NUM_KEYS-1:0]                 held_next;

    assign report_ready = (state == IDLE);
    assign voice_note   = vnote;

    voice_picker #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W),
        .AGE_W      (AGE_W)
    ) u_picker (
        .active    (voice_active),
        .ages      (age),
        .free_idx  (free_idx),
        .free_hit  (free_hit),
        .steal_idx (steal_idx)
    );

    always_comb begin
        rollover = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++)
            if (keycodes[8*k +: 8] == ROLLOVER) rollover = 1'b1;
    end

    always_comb begin
        cur_key        = NONE;
        cur_held_start = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (idx == CNT_W'(k)) begin
                cur_key        = rep[k];
                cur_held_start = held_start[k];
            end
        end
        held_now = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++)
            if (voice_active[v] && vkey[v] == cur_key) held_now = 1'b1;
        km       = key_map(cur_key);
        alloc    = (state == PRESS) && km.hit && !held_now && !cur_held_start;
        target   = free_hit ? free_idx : steal_idx;
        new_note = NOTE_W'(octave_base(octaveBase)) + NOTE_W'(km.offset);
    end

    // Keys held when PRESS begins stay claimed even if a steal evicts them.
    always_comb begin
        rel_drop  = '0;
        held_next = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            logic present;
            present = 1'b0;
            for (int k = 0; k < NUM_KEYS; k++)
                if (rep[k] == vkey[v]) present = 1'b1;
            rel_drop[v] = (idx == CNT_W'(v)) && voice_active[v] && !present;
        end
        for (int k = 0; k < NUM_KEYS; k++)
            for (int v = 0; v < NUM_VOICES; v++)
                if (rep[k] != NONE && voice_active[v] && vkey[v] == rep[k])
                    held_next[k] = 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            idx          <= '0;
            rep          <= '0;
            held_start   <= '0;
            vkey         <= '0;
            age          <= '0;
            vnote        <= '0;
            voice_active <= '0;
            voice_trig   <= '0;
            voice_off    <= '0;
        end else begin
            voice_trig <= '0;
            voice_off  <= '0;
            unique case (state)
                IDLE: begin
                    if (report_valid) begin
                        rep   <= keycodes;
                        idx   <= '0;
                        state <= rollover ? DONE : REL;
                    end
                end
                REL: begin
                    voice_active <= voice_active & ~rel_drop;
                    voice_off    <= rel_drop;
                    if (idx == CNT_W'(NUM_VOICES - 1)) begin
                        held_start <= held_next;
                        idx        <= '0;
                        state      <= PRESS;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                PRESS: begin
                    if (alloc) begin
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (target == IDX_W'(v)) begin
                                vkey[v]         <= cur_key;
                                vnote[v]        <= new_note;
                                age[v]          <= '0;
                                voice_active[v] <= 1'b1;
                                voice_trig[v]   <= 1'b1;
                            end else if (voice_active[v] && age[v] != AGE_MAX) begin
                                age[v] <= age[v] + 1'b1;
                            end
                        end
                    end
                    if (idx == CNT_W'(NUM_KEYS - 1)) begin
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_note_alloc.sv
// Directed bench for poly_note_alloc: per-report pulse timing, notes,
// steals, rollover, octave table edges and asynchronous reset.
module tb_poly_note_alloc;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        report_valid = 1'b0;
    logic        report_ready;
    logic [47:0] keycodes = '0;
    logic [7:0]  octaveBase = 8'h80;
    logic [3:0]  voice_active;
    logic [27:0] voice_note;
    logic [3:0]  voice_trig;
    logic [3:0]  voice_off;

    int n_cmp = 0;
    int n_err = 0;
    int trig_s[4];
    int off_s[4];
    logic [3:0] trig_m;
    logic [3:0] off_m;
    int lat;

    poly_note_alloc dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .report_valid (report_valid),
        .report_ready (report_ready),
        .keycodes     (keycodes),
        .octaveBase   (octaveBase),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .voice_trig   (voice_trig),
        .voice_off    (voice_off)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rpt(input logic [7:0] b0, b1, b2, b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    function automatic int note(input int v);
        return int'(voice_note[v*7 +: 7]);
    endfunction

    // s counts samples after the accepting edge; lat = first s with ready high
    task automatic send(input logic [47:0] kc, input logic [7:0] ob);
        @(negedge Clk);
        keycodes     = kc;
        octaveBase   = ob;
        report_valid = 1'b1;
        @(posedge Clk);
        #1 report_valid = 1'b0;
        trig_m = '0;
        off_m  = '0;
        lat    = -1;
        for (int v = 0; v < 4; v++) begin
            trig_s[v] = -1;
            off_s[v]  = -1;
        end
        for (int s = 0; s < 30 && lat < 0; s++) begin
            @(negedge Clk);
            for (int v = 0; v < 4; v++) begin
                if (voice_trig[v]) begin trig_m[v] = 1'b1; trig_s[v] = s; end
                if (voice_off[v])  begin off_m[v]  = 1'b1; off_s[v]  = s; end
            end
            if (report_ready) lat = s;
        end
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_active", int'(voice_active), 0);
        chk("rst_note", int'(voice_note), 0);
        chk("rst_trig", int'(voice_trig), 0);
        chk("rst_off", int'(voice_off), 0);
        chk("rst_ready", int'(report_ready), 1);

        send(rpt(8'h1D, 0, 0, 0, 0, 0), 8'h80);
        chk("t1_trig_m", int'(trig_m), 4'b0001);
        chk("t1_trig_s0", trig_s[0], 5);
        chk("t1_off_m", int'(off_m), 0);
        chk("t1_lat", lat, 11);
        chk("t1_active", int'(voice_active), 4'b0001);
        chk("t1_note0", note(0), 6);

        send(rpt(8'h1D, 0, 0, 0, 0, 0), 8'h80);
        chk("t2_trig_m", int'(trig_m), 0);
        chk("t2_off_m", int'(off_m), 0);
        chk("t2_active", int'(voice_active), 4'b0001);
        chk("t2_lat", lat, 11);

        send(rpt(0, 0, 0, 0, 0, 0), 8'h80);
        chk("t3_off_m", int'(off_m), 4'b0001);
        chk("t3_off_s0", off_s[0], 1);
        chk("t3_trig_m", int'(trig_m), 0);
        chk("t3_active", int'(voice_active), 0);

        send(rpt(8'h1D, 8'h1B, 8'h06, 8'h19, 0, 0), 8'h40);
        chk("t4_trig_m", int'(trig_m), 4'b1111);
        chk("t4_off_m", int'(off_m), 0);
        chk("t4_trig_s0", trig_s[0], 5);
        chk("t4_trig_s1", trig_s[1], 6);
        chk("t4_trig_s2", trig_s[2], 7);
        chk("t4_trig_s3", trig_s[3], 8);
        chk("t4_note0", note(0), 18);
        chk("t4_note1", note(1), 20);
        chk("t4_note2", note(2), 22);
        chk("t4_note3", note(3), 24);

        send(rpt(8'h1B, 8'h06, 8'h19, 8'h05, 8'h1D, 0), 8'h40);
        chk("t5_off_m", int'(off_m), 0);
        chk("t5_trig_m", int'(trig_m), 4'b0001);
        chk("t5_trig_s0", trig_s[0], 8);
        chk("t5_note0", note(0), 26);
        chk("t5_note1", note(1), 20);
        chk("t5_active", int'(voice_active), 4'b1111);

        send(rpt(8'h1B, 8'h01, 0, 0, 0, 0), 8'h40);
        chk("t6_trig_m", int'(trig_m), 0);
        chk("t6_off_m", int'(off_m), 0);
        chk("t6_lat", lat, 1);
        chk("t6_active", int'(voice_active), 4'b1111);
        chk("t6_note0", note(0), 26);
        chk("t6_note3", note(3), 24);

        send(rpt(8'h05, 8'h06, 8'h19, 8'h1B, 8'h04, 0), 8'h40);
        chk("t7_off_m", int'(off_m), 0);
        chk("t7_trig_m", int'(trig_m), 4'b0010);
        chk("t7_trig_s1", trig_s[1], 9);
        chk("t7_note1", note(1), 23);
        chk("t7_note0", note(0), 26);

        @(negedge Clk);
        keycodes     = rpt(8'h16, 8'h07, 8'h09, 0, 0, 0);
        octaveBase   = 8'h80;
        report_valid = 1'b1;
        @(posedge Clk);
        #1 report_valid = 1'b0;
        repeat (7) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("t8_rst_active", int'(voice_active), 0);
        chk("t8_rst_note", int'(voice_note), 0);
        chk("t8_rst_trig", int'(voice_trig), 0);
        chk("t8_rst_off", int'(voice_off), 0);
        chk("t8_rst_ready", int'(report_ready), 1);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        chk("t8_post_ready", int'(report_ready), 1);
        chk("t8_post_active", int'(voice_active), 0);

        send(rpt(8'h2F, 8'h2F, 8'h1D, 0, 8'h50, 0), 8'h03);
        chk("t9_trig_m", int'(trig_m), 4'b0011);
        chk("t9_trig_s0", trig_s[0], 5);
        chk("t9_trig_s1", trig_s[1], 7);
        chk("t9_note0", note(0), 120);
        chk("t9_note1", note(1), 90);

        send(rpt(8'h2F, 8'h1D, 0, 0, 0, 0), 8'h80);
        chk("t10_trig_m", int'(trig_m), 0);
        chk("t10_off_m", int'(off_m), 0);
        chk("t10_note0", note(0), 120);
        chk("t10_note1", note(1), 90);
        chk("t10_active", int'(voice_active), 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/poly_note_alloc.md
# poly_note_alloc

Polyphonic keyboard-to-voice allocator. It takes a full USB HID boot-keyboard report of up to NUM_KEYS simultaneous keycodes and maps each musical key to a note index. It assigns held notes to NUM_VOICES synth voices and emits per-voice one-cycle trigger and release pulses. It sits between the USB keyboard interface and the oscillator/envelope voice bank, replacing the single-voice note parser.

## Interface
- NUM_KEYS, 6: keycode slots per report.
- NUM_VOICES, 4: voice count, ≥1.
- NOTE_W, 7: note index width (max index 120).
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous, active-low reset.
- report_valid  in  1  new report present.
- report_ready  out  1  block accepts a report; high in IDLE only.
- keycodes  in  8*NUM_KEYS  slot k at bits [8k+7:8k].
- octaveBase  in  8  one-hot octave select; sampled at each note-on.
- voice_active  out  NUM_VOICES  voice holds a note.
- voice_note  out  NUM_VOICES*NOTE_W  note index per voice.
- voice_trig  out  NUM_VOICES  one-cycle note-on pulse.
- voice_off  out  NUM_VOICES  one-cycle note-off pulse.

## Operation
- A report is accepted on Clk when report_valid && report_ready, and is latched internally.
- If any slot is 0x01 (rollover error), the report is discarded. In that case there are no events, state is unchanged, and the block returns to IDLE next cycle.
- Slots equal to 0x00, unmapped keycodes and duplicate slots are ignored.
- Key map (keycode→offset): 1D→0, 1B→2, 06→4, 19→6, 05→8, 11→10, 10→12, 36→14, 37→16, 38→18, 04→5, 16→7, 07→9, 09→11, 0A→13, 0B→15, 0D→17, 0E→19, 0F→21, 33→23, 34→25, 14→10, 1A→12, 08→14, 15→16, 17→18, 1C→20, 18→22, 0C→24, 12→26, 13→28, 2F→30.
- Octave base (octaveBase→base): 80→6, 40→18, 20→30, 10→42, 08→54, 04→66, 02→78, 01→90, any other value→90.
- Note index = base + offset, computed in NOTE_W bits.
- Each voice stores its source keycode, note index and age (0..NUM_VOICES-1).
- States: IDLE → (accept) REL → PRESS → DONE → IDLE.
- REL: scans one voice per cycle, index 0 upward. An active voice whose keycode is absent from the report goes inactive and pulses voice_off.
- PRESS: scans one slot per cycle, slot 0 upward. A mapped key not already held by any voice is allocated:
  - Allocation takes the lowest-index inactive voice.
  - If no voice is free, allocation steals the voice with the largest age (lowest index on ties).
- On allocation:
  - The target voice gets keycode, note and age 0, goes active and pulses voice_trig.
  - Every other active voice increments its age, saturating at NUM_VOICES-1.
  - A steal pulses voice_trig only, never voice_off.
- A key already held produces no retrigger.
- octaveBase changes never retune held voices.

## Timing
- Reset values: voice_active=0, voice_note=0, voice_trig=0, voice_off=0, ages=0, state IDLE, report_ready=1.
- Reset is asynchronous at any point, including mid-scan; a partially processed report is lost with no pulses.
- Accept-to-ready latency is NUM_VOICES+NUM_KEYS+1 cycles (11 at defaults). A rollover report takes 1 cycle.
- voice_trig and voice_off are registered. Each is high exactly one cycle, in the cycle after the scan step that caused it.
- voice_active and voice_note update in the same cycle as the pulse.
- Release of one voice and trigger of another happen in different cycles, since REL always completes before PRESS.
- A release and a re-press of the same key cannot occur within one report.
- report_valid while report_ready=0 is ignored. The upstream block holds the report until it is accepted.

## Structure
- Package poly_note_pkg: state enum (IDLE, REL, PRESS, DONE), the key-map function keycode→{hit, offset[4:0]}, the octave-base function, and the ROLLOVER/NONE keycode constants.
- Sub-module voice_picker: combinational. Inputs are voice_active and ages. Outputs are free_idx, free_hit and steal_idx.

## Test plan
- After reset, report {1D,0,0,0,0,0} with octaveBase=80 → voice0 trig, note 6, ready again after 11 cycles.
- Same report repeated → no pulses, voice0 still active. Then report of all zeros → voice0 off pulse, inactive.
- Report {1D,1B,06,19,0,0} with octaveBase=40 → voices 0–3 trig in PRESS cycles 1–4, notes 18, 20, 22, 24.
- Voices full (1D,1B,06,19 held), new report {1B,06,19,05,1D,0} → no release; key 05 steals voice0 (age 3) with note 26 and no voice_off. Key 1D, already held, is not retriggered.
- Report containing 0x01 while voices are held → no events, state unchanged, ready after 1 cycle.
- Reset_n pulled low mid-PRESS → all outputs 0 immediately, ready=1 after release.
